// File: rtl/product_stream_buffer.sv
// Captures the multiplier's product block stream into a dual-port BRAM and replays it
// downstream under valid/ready; a small skid FIFO hides the 2-cycle BRAM read latency.
module product_stream_buffer #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    localparam int NUM_BLOCKS   = 2 * BITS_IN_NUM / REGISTER_SIZE,
    localparam int CNT_WIDTH    = $clog2(NUM_BLOCKS + 1)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     valid_in,
    input  logic                     final_in,
    output logic                     ready_out,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     last_out,
    output logic [CNT_WIDTH-1:0]     count_out,
    output logic                     overflow_out,
    output logic                     short_out
);
    localparam int ADDR_WIDTH = $clog2(NUM_BLOCKS);
    localparam logic [CNT_WIDTH-1:0] NUM_BLOCKS_C = CNT_WIDTH'(NUM_BLOCKS);

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                   state_r;
    logic [REGISTER_SIZE-1:0] mem_r [NUM_BLOCKS];
    logic [CNT_WIDTH-1:0]     count_r, rd_ptr_r, count_next_s;
    logic                     we_s;
    logic [ADDR_WIDTH-1:0]    waddr_s, raddr_s;

    logic                     rd_v1_r, rd_v2_r, rd_last1_r, rd_last2_r;
    logic [REGISTER_SIZE-1:0] rd_q1_r, rd_q2_r;
    logic                     issue_s, issue_last_s;
    logic [2:0]               occupancy_s;

    logic [REGISTER_SIZE-1:0] fifo_data_r [4];
    logic                     fifo_last_r [4];
    logic [1:0]               fifo_wr_r, fifo_rd_r;
    logic [2:0]               fifo_cnt_r;
    logic                     load_s, pop_s, bypass_s, push_s, fifo_empty_s;

    logic                     ready_r, valid_r, last_r, overflow_r, short_r;
    logic [REGISTER_SIZE-1:0] data_r;

    // Capture-side write enable; blocks past NUM_BLOCKS are multiplier repeats and are dropped.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = '0;
        if (state_r == IDLE) begin
            we_s    = valid_in;
            waddr_s = '0;
        end else if (state_r == CAPTURE) begin
            we_s    = valid_in && (count_r < NUM_BLOCKS_C);
            waddr_s = count_r[ADDR_WIDTH-1:0];
        end else begin
            we_s    = 1'b0;
            waddr_s = '0;
        end
        count_next_s = count_r + CNT_WIDTH'(we_s);
    end

    // Reads are issued only when the FIFO plus in-flight reads leave room for the result.
    always_comb begin
        occupancy_s  = fifo_cnt_r + 3'(rd_v1_r) + 3'(rd_v2_r);
        issue_s      = (state_r == DRAIN) && (rd_ptr_r < count_r) && (occupancy_s < 3'd4);
        issue_last_s = (rd_ptr_r == count_r - CNT_WIDTH'(1));
        raddr_s      = rd_ptr_r[ADDR_WIDTH-1:0];
        load_s       = !valid_r || ready_in;
        fifo_empty_s = (fifo_cnt_r == 3'd0);
        pop_s        = load_s && !fifo_empty_s;
        bypass_s     = load_s && fifo_empty_s && rd_v2_r;
        push_s       = rd_v2_r && !bypass_s;
    end

    // Dual-port block RAM with a two-stage registered read path.
    always_ff @(posedge clk_in) begin
        if (we_s) begin
            mem_r[waddr_s] <= data_in;
        end
        rd_q1_r <= mem_r[raddr_s];
        rd_q2_r <= rd_q1_r;
    end

    // Skid FIFO storage; occupancy is tracked with reset in the control block.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_data_r[fifo_wr_r] <= rd_q2_r;
            fifo_last_r[fifo_wr_r] <= rd_last2_r;
        end
    end

    // Control FSM, read pipeline valids, FIFO pointers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= IDLE;
            count_r    <= '0;
            rd_ptr_r   <= '0;
            rd_v1_r    <= 1'b0;
            rd_v2_r    <= 1'b0;
            rd_last1_r <= 1'b0;
            rd_last2_r <= 1'b0;
            fifo_wr_r  <= 2'd0;
            fifo_rd_r  <= 2'd0;
            fifo_cnt_r <= 3'd0;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            data_r     <= '0;
            overflow_r <= 1'b0;
            short_r    <= 1'b0;
        end else begin
            rd_v1_r    <= issue_s;
            rd_v2_r    <= rd_v1_r;
            rd_last1_r <= issue_last_s;
            rd_last2_r <= rd_last1_r;
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + CNT_WIDTH'(1);
            end
            if (push_s) begin
                fifo_wr_r <= fifo_wr_r + 2'd1;
            end
            if (pop_s) begin
                fifo_rd_r <= fifo_rd_r + 2'd1;
            end
            fifo_cnt_r <= fifo_cnt_r + 3'(push_s) - 3'(pop_s);

            // Older FIFO entries take precedence over the data just leaving the BRAM.
            if (load_s) begin
                if (!fifo_empty_s) begin
                    data_r  <= fifo_data_r[fifo_rd_r];
                    last_r  <= fifo_last_r[fifo_rd_r];
                    valid_r <= 1'b1;
                end else if (rd_v2_r) begin
                    data_r  <= rd_q2_r;
                    last_r  <= rd_last2_r;
                    valid_r <= 1'b1;
                end else begin
                    valid_r <= 1'b0;
                end
            end

            case (state_r)
                IDLE: begin
                    if (valid_in) begin
                        count_r <= CNT_WIDTH'(1);
                        ready_r <= 1'b0;
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    count_r <= count_next_s;
                    if (final_in) begin
                        rd_ptr_r <= '0;
                        state_r  <= DRAIN;
                        if (count_next_s < NUM_BLOCKS_C) begin
                            short_r <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (valid_in) begin
                        overflow_r <= 1'b1;
                    end
                    if (valid_r && ready_in && last_r) begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready_out    = ready_r;
    assign data_out     = data_r;
    assign valid_out    = valid_r;
    assign last_out     = last_r;
    assign count_out    = count_r;
    assign overflow_out = overflow_r;
    assign short_out    = short_r;
endmodule
